multi_arch_adder: RTL and testbench

// - Registered WORD_WIDTH-bit adder computing a+b+c_in with three architectures: ripple-carry (RCA),
//   two-level carry-lookahead (CLAA) and sectioned carry-select (CSA).
// - Reference/utility arithmetic block: mode selects which result is returned.
// - Optional cross-check compares all three results each operation.

---
 rtl/multi_arch_adder_pkg.sv | 16 +
 rtl/multi_arch_adder_if.sv | 27 ++
 rtl/multi_arch_adder_cla_group4.sv | 48 ++++
 rtl/multi_arch_adder.sv | 144 ++++++++++++++
 tb/tb_multi_arch_adder.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/multi_arch_adder_pkg.sv
// Shared types and helpers for the multi-architecture adder.
package adder_pkg;

  typedef enum logic [1:0] {
    MODE_RCA  = 2'd0,
    MODE_CLAA = 2'd1,
    MODE_CSA  = 2'd2,
    MODE_RSVD = 2'd3
  } adder_mode_t;

  // Number of carry-select sections; the top section takes the remainder.
  function automatic int csa_sections(input int word_width, input int unit_width);
    return (word_width + unit_width - 1) / unit_width;
  endfunction

endpackage

// File: rtl/multi_arch_adder_if.sv
// Operand/result bundle for multi_arch_adder; master drives operands, slave returns results.
interface multi_arch_adder_if #(
  parameter int WORD_WIDTH = 16
);
  import adder_pkg::*;

  logic                  in_valid;
  adder_mode_t           mode;
  logic [WORD_WIDTH-1:0] a;
  logic [WORD_WIDTH-1:0] b;
  logic                  c_in;
  logic                  out_valid;
  logic [WORD_WIDTH-1:0] sum;
  logic                  c_out;
  logic                  ovf;
  logic                  mismatch;

  modport master (
    output in_valid, mode, a, b, c_in,
    input  out_valid, sum, c_out, ovf, mismatch
  );

  modport slave (
    input  in_valid, mode, a, b, c_in,
    output out_valid, sum, c_out, ovf, mismatch
  );
endinterface

// File: rtl/multi_arch_adder_cla_group4.sv
// Lookahead cell of up to 4 bits: sums plus group propagate/generate for the second level.
module cla_group4 #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_c,
  output logic [N-1:0] o_s,
  output logic         o_p,
  output logic         o_g
);
  logic [N-1:0] w_p;
  logic [N-1:0] w_g;
  logic [N-1:0] w_c;
  logic         w_term;
  logic         w_acc;
  logic         w_gacc;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;
  assign o_s = w_p ^ w_c;
  assign o_p = &w_p;
  assign o_g = w_gacc;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    w_c    = '0;
    w_term = 1'b0;
    w_acc  = 1'b0;
    w_gacc = 1'b0;
    // Carry into bit i expanded as sum-of-products, not rippled.
    for (int i = 0; i < N; i++) begin
      w_acc = i_c;
      for (int m = 0; m < i; m++) w_acc = w_acc & w_p[m];
      for (int j = 0; j < i; j++) begin
        w_term = w_g[j];
        for (int m = j + 1; m < i; m++) w_term = w_term & w_p[m];
        w_acc = w_acc | w_term;
      end
      w_c[i] = w_acc;
    end
    for (int j = 0; j < N; j++) begin
      w_term = w_g[j];
      for (int m = j + 1; m < N; m++) w_term = w_term & w_p[m];
      w_gacc = w_gacc | w_term;
    end
  end
endmodule

// File: rtl/multi_arch_adder.sv
// Registered a+b+c_in via ripple, carry-lookahead or carry-select; mode picks the result.
// Define ADDER_CROSSCHECK_EN to compare all three results and flag disagreement on mismatch.
module multi_arch_adder
  import adder_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int UNIT_WIDTH = 5
) (
  input  logic               clk,
  input  logic               reset,
  multi_arch_adder_if.slave  bus
);
  localparam int W  = WORD_WIDTH;
  localparam int NG = (W + 3) / 4;
  localparam int NS = csa_sections(W, UNIT_WIDTH);

  logic [W-1:0] w_a, w_b;
  logic         w_cin;
  assign w_a   = bus.a;
  assign w_b   = bus.b;
  assign w_cin = bus.c_in;

  // Ripple-carry: each bit's carry comes from the previous generate block.
  logic [W-1:0] w_rca_sum;
  logic         w_rca_cout;
  for (genvar i = 0; i < W; i++) begin : g_rca
    logic w_ci, w_co;
    if (i == 0) begin : g_lsb
      assign w_ci = w_cin;
    end else begin : g_chain
      assign w_ci = g_rca[i-1].w_co;
    end
    assign w_rca_sum[i] = w_a[i] ^ w_b[i] ^ w_ci;
    assign w_co         = (w_a[i] & w_b[i]) | (w_ci & (w_a[i] ^ w_b[i]));
  end
  assign w_rca_cout = g_rca[W-1].w_co;

  // Two-level lookahead: 4-bit groups, top group narrower when W is not a multiple of 4.
  logic [W-1:0]  w_claa_sum;
  logic          w_claa_cout;
  logic [NG-1:0] w_grp_p, w_grp_g;
  logic [NG:0]   w_grp_c;
  logic          w_term, w_acc;
  for (genvar k = 0; k < NG; k++) begin : g_cla
    localparam int LO = 4 * k;
    localparam int GW = (W - LO < 4) ? (W - LO) : 4;
    cla_group4 #(.N(GW)) u_grp (
      .i_a (w_a[LO +: GW]),
      .i_b (w_b[LO +: GW]),
      .i_c (w_grp_c[k]),
      .o_s (w_claa_sum[LO +: GW]),
      .o_p (w_grp_p[k]),
      .o_g (w_grp_g[k])
    );
  end

  always_comb begin
    w_grp_c    = '0;
    w_term     = 1'b0;
    w_acc      = 1'b0;
    w_grp_c[0] = w_cin;
    for (int k = 0; k < NG; k++) begin
      w_acc = w_cin;
      for (int m = 0; m <= k; m++) w_acc = w_acc & w_grp_p[m];
      for (int j = 0; j <= k; j++) begin
        w_term = w_grp_g[j];
        for (int m = j + 1; m <= k; m++) w_term = w_term & w_grp_p[m];
        w_acc = w_acc | w_term;
      end
      w_grp_c[k+1] = w_acc;
    end
  end
  assign w_claa_cout = w_grp_c[NG];

  // Carry-select: higher sections precompute both carry-in cases and pick one.
  logic [W-1:0] w_csa_sum;
  logic         w_csa_cout;
  for (genvar k = 0; k < NS; k++) begin : g_csa
    localparam int LO = k * UNIT_WIDTH;
    localparam int SW = (W - LO < UNIT_WIDTH) ? (W - LO) : UNIT_WIDTH;
    logic w_ci, w_co;
    if (k == 0) begin : g_rip
      logic [SW:0] w_s;
      assign w_ci = w_cin;
      assign w_s  = {1'b0, w_a[LO +: SW]} + {1'b0, w_b[LO +: SW]} + {{SW{1'b0}}, w_ci};
      assign {w_co, w_csa_sum[LO +: SW]} = w_s;
    end else begin : g_sel
      logic [SW:0] w_s0, w_s1;
      assign w_ci = g_csa[k-1].w_co;
      assign w_s0 = {1'b0, w_a[LO +: SW]} + {1'b0, w_b[LO +: SW]};
      assign w_s1 = {1'b0, w_a[LO +: SW]} + {1'b0, w_b[LO +: SW]} + {{SW{1'b0}}, 1'b1};
      assign {w_co, w_csa_sum[LO +: SW]} = w_ci ? w_s1 : w_s0;
    end
  end
  assign w_csa_cout = g_csa[NS-1].w_co;

  logic [W-1:0] w_sel_sum;
  logic         w_sel_cout, w_sel_ovf, w_mismatch;
  always_comb begin
    w_sel_sum  = w_rca_sum;
    w_sel_cout = w_rca_cout;
    case (bus.mode)
      MODE_CLAA: begin w_sel_sum = w_claa_sum; w_sel_cout = w_claa_cout; end
      MODE_CSA:  begin w_sel_sum = w_csa_sum;  w_sel_cout = w_csa_cout;  end
      default:   ;
    endcase
  end
  // a^b^sum at the MSB recovers the carry into the MSB.
  assign w_sel_ovf = w_a[W-1] ^ w_b[W-1] ^ w_sel_sum[W-1] ^ w_sel_cout;

`ifdef ADDER_CROSSCHECK_EN
  assign w_mismatch = ({w_rca_cout, w_rca_sum} != {w_claa_cout, w_claa_sum}) ||
                      ({w_rca_cout, w_rca_sum} != {w_csa_cout, w_csa_sum});
`else
  assign w_mismatch = 1'b0;
`endif

  logic         r_out_valid, r_c_out, r_ovf, r_mismatch;
  logic [W-1:0] r_sum;
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_c_out     <= 1'b0;
      r_ovf       <= 1'b0;
      r_mismatch  <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_sum      <= w_sel_sum;
        r_c_out    <= w_sel_cout;
        r_ovf      <= w_sel_ovf;
        r_mismatch <= w_mismatch;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.c_out     = r_c_out;
  assign bus.ovf       = r_ovf;
  assign bus.mismatch  = r_mismatch;
endmodule

// File: tb/tb_multi_arch_adder.sv
// Directed and random checks of multi_arch_adder at 16 bits (5-bit CSA units) and 12 bits.
module tb_multi_arch_adder;
  import adder_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  multi_arch_adder_if #(.WORD_WIDTH(16)) bus16 ();
  multi_arch_adder_if #(.WORD_WIDTH(12)) bus12 ();

  multi_arch_adder #(.WORD_WIDTH(16), .UNIT_WIDTH(5)) u_dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16)
  );

  multi_arch_adder #(.WORD_WIDTH(12), .UNIT_WIDTH(5)) u_dut12 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus12)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic op16(input string tag, input adder_mode_t mode, input logic [15:0] a,
                      input logic [15:0] b, input logic cin, input logic [15:0] es,
                      input logic ec, input logic eo);
    @(negedge clk);
    bus16.in_valid = 1'b1;
    bus16.mode     = mode;
    bus16.a        = a;
    bus16.b        = b;
    bus16.c_in     = cin;
    @(posedge clk);
    #1;
    check({tag, ".valid"},    32'(bus16.out_valid), 32'd1);
    check({tag, ".sum"},      32'(bus16.sum),       32'(es));
    check({tag, ".cout"},     32'(bus16.c_out),     32'(ec));
    check({tag, ".ovf"},      32'(bus16.ovf),       32'(eo));
    check({tag, ".mismatch"}, 32'(bus16.mismatch),  32'd0);
    bus16.in_valid = 1'b0;
  endtask

  task automatic op12(input string tag, input adder_mode_t mode, input logic [11:0] a,
                      input logic [11:0] b, input logic cin, input logic [11:0] es,
                      input logic ec, input logic eo);
    @(negedge clk);
    bus12.in_valid = 1'b1;
    bus12.mode     = mode;
    bus12.a        = a;
    bus12.b        = b;
    bus12.c_in     = cin;
    @(posedge clk);
    #1;
    check({tag, ".valid"},    32'(bus12.out_valid), 32'd1);
    check({tag, ".sum"},      32'(bus12.sum),       32'(es));
    check({tag, ".cout"},     32'(bus12.c_out),     32'(ec));
    check({tag, ".ovf"},      32'(bus12.ovf),       32'(eo));
    check({tag, ".mismatch"}, 32'(bus12.mismatch),  32'd0);
    bus12.in_valid = 1'b0;
  endtask

  logic [15:0] bb_sum [3];
  logic [15:0] bb_a   [3];
  logic [15:0] bb_b   [3];
  logic        bb_c   [3];

  initial begin
    logic [15:0] ra16, rb16;
    logic [11:0] ra12, rb12;
    logic        rc;
    logic [16:0] full16;
    logic [12:0] full12;
    adder_mode_t m;

    reset          = 1'b1;
    bus16.in_valid = 1'b0; bus16.mode = MODE_RCA; bus16.a = '0; bus16.b = '0; bus16.c_in = 1'b0;
    bus12.in_valid = 1'b0; bus12.mode = MODE_RCA; bus12.a = '0; bus12.b = '0; bus12.c_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.valid",    32'(bus16.out_valid), 32'd0);
    check("rst.sum",      32'(bus16.sum),       32'd0);
    check("rst.cout",     32'(bus16.c_out),     32'd0);
    check("rst.ovf",      32'(bus16.ovf),       32'd0);
    check("rst.mismatch", 32'(bus16.mismatch),  32'd0);
    check("rst12.sum",    32'(bus12.sum),       32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Hand-computed vectors, every mode including the reserved one.
    for (int i = 0; i < 4; i++) begin
      m = adder_mode_t'(i);
      op16($sformatf("m%0d.basic", i), m, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
      op16($sformatf("m%0d.wrap", i),  m, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      op16($sformatf("m%0d.povf", i),  m, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      op16($sformatf("m%0d.novf", i),  m, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
      op16($sformatf("m%0d.cin", i),   m, 16'h001F, 16'h0000, 1'b1, 16'h0020, 1'b0, 1'b0);
      op12($sformatf("w12m%0d.wrap", i), m, 12'hFFF, 12'h000, 1'b1, 12'h000, 1'b1, 1'b0);
      op12($sformatf("w12m%0d.sec", i),  m, 12'h01F, 12'h001, 1'b0, 12'h020, 1'b0, 1'b0);
      op12($sformatf("w12m%0d.top", i),  m, 12'h3FF, 12'h401, 1'b0, 12'h800, 1'b0, 1'b1);
    end

    // Random operands checked against the bench's own wide addition.
    for (int i = 0; i < 4; i++) begin
      m = adder_mode_t'(i);
      for (int n = 0; n < 10; n++) begin
        ra16   = 16'($urandom);
        rb16   = 16'($urandom);
        rc     = 1'($urandom_range(0, 1));
        full16 = {1'b0, ra16} + {1'b0, rb16} + {16'd0, rc};
        op16($sformatf("r16.m%0d.%0d", i, n), m, ra16, rb16, rc, full16[15:0], full16[16],
             (ra16[15] == rb16[15]) && (full16[15] != ra16[15]));
        ra12   = 12'($urandom);
        rb12   = 12'($urandom);
        full12 = {1'b0, ra12} + {1'b0, rb12} + {12'd0, rc};
        op12($sformatf("r12.m%0d.%0d", i, n), m, ra12, rb12, rc, full12[11:0], full12[12],
             (ra12[11] == rb12[11]) && (full12[11] != ra12[11]));
      end
    end

    // Back-to-back issue, then an idle cycle with junk operands must hold the last result.
    bb_a[0] = 16'h0001; bb_b[0] = 16'h0002; bb_c[0] = 1'b0; bb_sum[0] = 16'h0003;
    bb_a[1] = 16'h1000; bb_b[1] = 16'h0100; bb_c[1] = 1'b1; bb_sum[1] = 16'h1101;
    bb_a[2] = 16'hABCD; bb_b[2] = 16'h1111; bb_c[2] = 1'b0; bb_sum[2] = 16'hBCDE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus16.in_valid = 1'b1;
      bus16.mode     = adder_mode_t'(i);
      bus16.a        = bb_a[i];
      bus16.b        = bb_b[i];
      bus16.c_in     = bb_c[i];
      @(posedge clk);
      #1;
      check($sformatf("b2b%0d.valid", i), 32'(bus16.out_valid), 32'd1);
      check($sformatf("b2b%0d.sum", i),   32'(bus16.sum),       32'(bb_sum[i]));
    end
    @(negedge clk);
    bus16.in_valid = 1'b0;
    bus16.a        = 16'hFFFF;
    bus16.b        = 16'hFFFF;
    @(posedge clk);
    #1;
    check("idle.valid", 32'(bus16.out_valid), 32'd0);
    check("idle.sum",   32'(bus16.sum),       32'hBCDE);
    check("idle.cout",  32'(bus16.c_out),     32'd0);

    // Reset wins over a simultaneous valid operation.
    @(negedge clk);
    reset          = 1'b1;
    bus16.in_valid = 1'b1;
    bus16.mode     = MODE_CLAA;
    bus16.a        = 16'hFFFF;
    bus16.b        = 16'h0001;
    bus16.c_in     = 1'b0;
    @(posedge clk);
    #1;
    check("rstv.valid", 32'(bus16.out_valid), 32'd0);
    check("rstv.sum",   32'(bus16.sum),       32'd0);
    check("rstv.cout",  32'(bus16.c_out),     32'd0);
    check("rstv.ovf",   32'(bus16.ovf),       32'd0);
    @(negedge clk);
    reset = 1'b0;
    op16("post_rst", MODE_CSA, 16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
